// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the elastic pipeline stage: storage state encoding and small scalar aliases.
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  typedef logic u1_t;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready beat channel. A beat moves on a rising clk edge iff valid && ready; the master
// holds valid and data stable until it moves, and ready may depend on valid but never the reverse.
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 64
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter used for the stage's bubble and back-pressure perf counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: one main entry driving the output plus an optional skid entry
// that lets in_ready come straight from state, breaking the combinational stall path.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SKID  = 1,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    pipe_stage_elastic_if.slave   in_if,
    pipe_stage_elastic_if.master  out_if,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      stall_cnt,
    output stage_state_e          state_dbg
);
    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    u1_t              main_v, skid_v, in_ready_int, accept, deliver;
    u1_t              bubble_inc, stall_inc;

    assign main_v  = (state_q != ST_EMPTY);
    assign skid_v  = (state_q == ST_FULL);

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready_int = !skid_v;
        end else begin : g_noskid
            assign in_ready_int = !main_v || out_if.ready;
        end
    endgenerate

    assign accept  = in_if.valid && in_ready_int;
    assign deliver = main_v && out_if.ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    main_d  = in_if.data;
                end
            end
            ST_BUSY: begin
                if (deliver && accept) begin
                    main_d = in_if.data;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end else if (accept && (SKID != 0)) begin
                    state_d = ST_FULL;
                    skid_d  = in_if.data;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        // Flush wins over any deliver/accept this cycle; an offered beat is silently dropped.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_if.ready  = in_ready_int;
    assign out_if.valid = main_v;
    assign out_if.data  = main_v ? main_q : '0;
    assign occupancy    = {1'b0, main_v} + {1'b0, skid_v};
    assign state_dbg    = state_q;

    assign bubble_inc = !main_v;
    assign stall_inc  = main_v && !out_if.ready;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid (A), no-skid (B) and narrow-counter (C) instances.
module tb_pipe_stage_elastic;
  import pipe_stage_elastic_pkg::*;

  localparam int W = 16;

  logic clk;
  logic reset;
  logic flush_a, flush_b, flush_c;
  int   n_tests;
  int   n_fail;

  pipe_stage_elastic_if #(.WIDTH(W)) a_in ();
  pipe_stage_elastic_if #(.WIDTH(W)) a_out ();
  pipe_stage_elastic_if #(.WIDTH(W)) b_in ();
  pipe_stage_elastic_if #(.WIDTH(W)) b_out ();
  pipe_stage_elastic_if #(.WIDTH(W)) c_in ();
  pipe_stage_elastic_if #(.WIDTH(W)) c_out ();

  logic [1:0]   a_occ, b_occ, c_occ;
  logic [31:0]  a_bub, a_stall, b_bub, b_stall;
  logic [3:0]   c_bub, c_stall;
  stage_state_e a_st, b_st, c_st;

  pipe_stage_elastic #(.WIDTH(W), .SKID(1), .CNT_W(32)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .in_if(a_in), .out_if(a_out),
    .occupancy(a_occ), .bubble_cnt(a_bub), .stall_cnt(a_stall), .state_dbg(a_st)
  );

  pipe_stage_elastic #(.WIDTH(W), .SKID(0), .CNT_W(32)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .in_if(b_in), .out_if(b_out),
    .occupancy(b_occ), .bubble_cnt(b_bub), .stall_cnt(b_stall), .state_dbg(b_st)
  );

  pipe_stage_elastic #(.WIDTH(W), .SKID(1), .CNT_W(4)) u_dut_c (
    .clk(clk), .reset(reset), .flush(flush_c), .in_if(c_in), .out_if(c_out),
    .occupancy(c_occ), .bubble_cnt(c_bub), .stall_cnt(c_stall), .state_dbg(c_st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [W-1:0] d, input logic rdy);
    a_in.valid = v;
    a_in.data  = d;
    a_out.ready = rdy;
  endtask

  task automatic drive_b(input logic v, input logic [W-1:0] d, input logic rdy);
    b_in.valid = v;
    b_in.data  = d;
    b_out.ready = rdy;
  endtask

  task automatic check_a_out(input string tag, input logic v, input logic [W-1:0] d);
    check({tag, "_valid"}, 64'(a_out.valid), 64'(v));
    check({tag, "_data"},  64'(a_out.data),  64'(d));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    c_in.valid = 1'b0; c_in.data = '0; c_out.ready = 1'b1;
    drive_b(1'b0, '0, 1'b1);

    // 1: reset held 3 cycles with a beat offered
    reset = 1'b1;
    drive_a(1'b1, 16'h55, 1'b1);
    repeat (3) tick();
    check_a_out("rst_out", 1'b0, 16'h0);
    check("rst_in_ready", 64'(a_in.ready), 64'd1);
    check("rst_occ", 64'(a_occ), 64'd0);
    check("rst_bub", 64'(a_bub), 64'd0);
    check("rst_stall", 64'(a_stall), 64'd0);
    check("rst_state", 64'(a_st), 64'(ST_EMPTY));
    check("rst_b_in_ready", 64'(b_in.ready), 64'd1);

    // 2: back-to-back streaming
    reset = 1'b0;
    drive_a(1'b1, 16'h11, 1'b1);
    tick();
    drive_a(1'b1, 16'h22, 1'b1);
    check_a_out("s1", 1'b1, 16'h11);
    check("s1_bub", 64'(a_bub), 64'd1);
    tick();
    drive_a(1'b1, 16'h33, 1'b1);
    check_a_out("s2", 1'b1, 16'h22);
    tick();
    drive_a(1'b0, 16'h0, 1'b1);
    check_a_out("s3", 1'b1, 16'h33);
    tick();
    check_a_out("s4", 1'b0, 16'h0);
    check("s4_bub", 64'(a_bub), 64'd1);
    check("s4_stall", 64'(a_stall), 64'd0);

    // 3: back-pressure into the skid entry
    drive_a(1'b1, 16'hA, 1'b0);
    tick();
    drive_a(1'b1, 16'hB, 1'b0);
    check_a_out("bp1", 1'b1, 16'hA);
    check("bp1_occ", 64'(a_occ), 64'd1);
    check("bp1_in_ready", 64'(a_in.ready), 64'd1);
    tick();
    drive_a(1'b1, 16'hC, 1'b0);
    check_a_out("bp2", 1'b1, 16'hA);
    check("bp2_occ", 64'(a_occ), 64'd2);
    check("bp2_in_ready", 64'(a_in.ready), 64'd0);
    check("bp2_state", 64'(a_st), 64'(ST_FULL));
    tick();
    check("bp3_occ", 64'(a_occ), 64'd2);
    check("bp3_stall", 64'(a_stall), 64'd2);
    drive_a(1'b1, 16'hC, 1'b1);
    settle();
    check("bp3_in_ready_reg", 64'(a_in.ready), 64'd0);
    tick();
    check_a_out("bp4", 1'b1, 16'hB);
    check("bp4_occ", 64'(a_occ), 64'd1);
    tick();
    drive_a(1'b0, 16'h0, 1'b1);
    check_a_out("bp5", 1'b1, 16'hC);
    tick();
    check_a_out("bp6", 1'b0, 16'h0);
    check("bp6_stall", 64'(a_stall), 64'd2);

    // 4: flush while FULL, with a beat offered in the flush cycle
    drive_a(1'b1, 16'hA, 1'b0);
    tick();
    drive_a(1'b1, 16'hB, 1'b0);
    tick();
    check("fl0_occ", 64'(a_occ), 64'd2);
    drive_a(1'b1, 16'hD, 1'b0);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    drive_a(1'b0, 16'h0, 1'b1);
    check_a_out("fl1", 1'b0, 16'h0);
    check("fl1_occ", 64'(a_occ), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a_out("fl_after", 1'b0, 16'h0);
    end

    // 5: no-skid instance, combinational in_ready
    drive_b(1'b1, 16'h1, 1'b0);
    settle();
    check("ns_in_ready_empty", 64'(b_in.ready), 64'd1);
    tick();
    check("ns_out1", 64'(b_out.data), 64'h1);
    check("ns_in_ready_stall", 64'(b_in.ready), 64'd0);
    tick();
    check("ns_occ_hold", 64'(b_occ), 64'd1);
    check("ns_out_hold", 64'(b_out.data), 64'h1);
    drive_b(1'b1, 16'h2, 1'b1);
    settle();
    check("ns_in_ready_go", 64'(b_in.ready), 64'd1);
    tick();
    drive_b(1'b1, 16'h3, 1'b1);
    check("ns_out2", 64'(b_out.data), 64'h2);
    tick();
    drive_b(1'b0, 16'h0, 1'b1);
    check("ns_out3", 64'(b_out.data), 64'h3);
    tick();
    check("ns_empty_valid", 64'(b_out.valid), 64'd0);
    check("ns_empty_occ", 64'(b_occ), 64'd0);

    // 6: reset while FULL, then counter saturation
    drive_a(1'b1, 16'h7, 1'b0);
    tick();
    drive_a(1'b1, 16'h8, 1'b0);
    tick();
    check("rf_occ_pre", 64'(a_occ), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_a(1'b0, 16'h0, 1'b1);
    check_a_out("rf", 1'b0, 16'h0);
    check("rf_occ", 64'(a_occ), 64'd0);
    check("rf_in_ready", 64'(a_in.ready), 64'd1);
    check("rf_stall", 64'(a_stall), 64'd0);
    check("rf_c_bub", 64'(c_bub), 64'd0);
    repeat (10) tick();
    check("sat_c_bub10", 64'(c_bub), 64'd10);
    repeat (10) tick();
    check("sat_c_bub20", 64'(c_bub), 64'd15);
    check("sat_a_bub20", 64'(a_bub), 64'd20);
    check("sat_c_stall", 64'(c_stall), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
